// File: rtl/uart_rx_pixel.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pixel
//  Purpose  : 8N1 UART receiver that rebuilds a serial image frame and emits
//             it as PIX_W-bit pixels, one strobe per pixel with its address.
//             The first received byte holds the frame MSBs. Pixels are
//             re-packed through a small accumulator.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             bit_in     - UART RX line, idle high, asynchronous to clk
//             pix_valid  - one-cycle pixel strobe
//             pix_data   - pixel value, held until the next strobe
//             pix_addr   - pixel index 0..N_PIX-1, held until the next strobe
//             frame_done - one-cycle pulse alongside the last pixel strobe
//             frame_err  - sticky error (bad stop bit or inter-byte timeout)
//             busy       - high while a frame is partially received
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_pixel #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PIX_W        = 18,
    parameter int N_PIX        = 784,
    parameter int TIMEOUT      = 16 * CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic [9:0]       pix_addr,
    output logic             frame_done,
    output logic             frame_err,
    output logic             busy
);

    localparam int C_N_BYTES = (N_PIX * PIX_W) / 8;
    localparam int C_TMR_W   = $clog2(CLKS_PER_BIT);
    localparam int C_IDLE_W  = $clog2(TIMEOUT);
    localparam int C_BCNT_W  = $clog2(C_N_BYTES + 1);
    localparam int C_FILL_W  = $clog2(PIX_W + 8 + 1);
    localparam int C_CAT_W   = PIX_W + 8;

    localparam logic [C_TMR_W-1:0]  C_HALF_M1  = C_TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_TMR_W-1:0]  C_BIT_M1   = C_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [C_IDLE_W-1:0] C_TO_M1    = C_IDLE_W'(TIMEOUT - 1);
    localparam logic [9:0]          C_LAST_PIX = 10'(N_PIX - 1);
    localparam logic [C_FILL_W-1:0] C_PIX_W    = C_FILL_W'(PIX_W);
    localparam logic [C_FILL_W-1:0] C_BYTE_W   = C_FILL_W'(8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_sync1;
    logic                r_sync2;
    logic [C_TMR_W-1:0]  r_tmr;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_byte_stb;
    logic [C_IDLE_W-1:0] r_idle_cnt;
    logic [C_BCNT_W-1:0] r_byte_cnt;
    logic [9:0]          r_pix_cnt;
    logic [PIX_W-1:0]    r_acc;
    logic [C_FILL_W-1:0] r_fill;

    logic                w_start_det;
    logic                w_bit_smp;
    logic                w_stop_ok;
    logic                w_stop_bad;
    logic                w_timeout;
    logic [C_CAT_W-1:0]  w_cat;
    logic [C_FILL_W-1:0] w_fill_sum;
    logic [C_FILL_W-1:0] w_fill_rem;
    logic                w_emit;
    logic [PIX_W-1:0]    w_pixel;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bit_in;
            r_sync2 <= r_sync1;
        end
    end

    // ---------------- RX state machine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start_det  = 1'b0;
        w_bit_smp    = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!r_sync2) begin
                    w_start_det  = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // A line back high at mid start bit is a glitch, not a byte.
                if (r_tmr == C_HALF_M1) w_state_next = r_sync2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (r_tmr == C_BIT_M1) begin
                    w_bit_smp = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (r_tmr == C_BIT_M1) begin
                    w_state_next = S_IDLE;
                    w_stop_ok    = r_sync2;
                    w_stop_bad   = !r_sync2;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit timer restarts on every state change and every data-bit sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_stb <= 1'b0;
        end else begin
            r_byte_stb <= w_stop_ok;
            if (r_state == S_IDLE || w_state_next != r_state || w_bit_smp) r_tmr <= '0;
            else                                                          r_tmr <= r_tmr + C_TMR_W'(1);
            if (r_state == S_IDLE) r_bit_idx <= '0;
            else if (w_bit_smp)    r_bit_idx <= r_bit_idx + 3'd1;
            // LSB arrives first, so shift in from the top.
            if (w_bit_smp) r_shift <= {r_sync2, r_shift[7:1]};
        end
    end

    // ---------------- Inter-byte timeout ----------------
    // Start detection outranks expiry, so a byte arriving on the last idle
    // clock keeps the frame alive.
    assign w_timeout = busy && (r_state == S_IDLE) && !w_start_det && (r_idle_cnt == C_TO_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_idle_cnt <= '0;
        else if (w_start_det || !busy)     r_idle_cnt <= '0;
        else if (r_state == S_IDLE)        r_idle_cnt <= (r_idle_cnt == C_TO_M1) ? '0 : r_idle_cnt + C_IDLE_W'(1);
    end

    // ---------------- Pixel packing ----------------
    // Fewer than PIX_W valid bits remain in r_acc between bytes, so its low
    // PIX_W bits plus the new byte always hold every pending bit.
    assign w_cat      = {r_acc, r_shift};
    assign w_fill_sum = r_fill + C_BYTE_W;
    assign w_emit     = (w_fill_sum >= C_PIX_W);
    assign w_fill_rem = w_fill_sum - C_PIX_W;
    assign w_pixel    = PIX_W'(w_cat >> w_fill_rem);
    assign busy       = (r_byte_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_addr   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            r_byte_cnt <= '0;
            r_pix_cnt  <= '0;
            r_acc      <= '0;
            r_fill     <= '0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (r_byte_stb) begin
                r_byte_cnt <= r_byte_cnt + C_BCNT_W'(1);
                r_acc      <= w_cat[PIX_W-1:0];
                r_fill     <= w_fill_sum;
                if (w_emit) begin
                    pix_valid <= 1'b1;
                    pix_data  <= w_pixel;
                    pix_addr  <= r_pix_cnt;
                    r_fill    <= w_fill_rem;
                    r_pix_cnt <= r_pix_cnt + 10'd1;
                    if (r_pix_cnt == C_LAST_PIX) begin
                        frame_done <= 1'b1;
                        r_pix_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_acc      <= '0;
                        r_fill     <= '0;
                    end
                end
            end else if (w_timeout) begin
                r_byte_cnt <= '0;
                r_pix_cnt  <= '0;
                r_acc      <= '0;
                r_fill     <= '0;
            end
            if (w_stop_bad || w_timeout) frame_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pixel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_pixel
//  Purpose  : Self-checking bench for uart_rx_pixel with a shortened frame
//             (16 pixels = 36 bytes) at 16 clocks per bit. The byte table
//             holds hand-packed pixel values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_pixel;

    localparam int CPB    = 16;
    localparam int NPIX   = 16;
    localparam int TO     = 16 * CPB;
    localparam int NBYTES = NPIX * 18 / 8;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        bit_in = 1'b1;
    logic        pix_valid;
    logic [17:0] pix_data;
    logic [9:0]  pix_addr;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    uart_rx_pixel #(
        .CLKS_PER_BIT (CPB),
        .PIX_W        (18),
        .N_PIX        (NPIX),
        .TIMEOUT      (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_addr   (pix_addr),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        bit          strobe;
        int          pidx;
        logic [17:0] pix;
    } vec_t;

    vec_t        tbl [18];
    int          n_cmp    = 0;
    int          n_err    = 0;
    int          done_cnt = 0;
    logic [27:0] q_pix [$];
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe monitor: records every pixel and checks strobe shape.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (pix_valid || frame_done)
                check("frame_done_align", {31'd0, frame_done},
                      {31'd0, (pix_valid && pix_addr == 10'(NPIX - 1))});
            if (pix_valid) begin
                check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
                q_pix.push_back({pix_addr, pix_data});
            end
            if (frame_done) done_cnt++;
        end
        prev_valid = pix_valid;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bit_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        bit_in = stop;
        repeat (CPB) @(negedge clk);
        bit_in = 1'b1;
    endtask

    // Sends frame bytes [first, last) from the table; byte j maps to tbl[j%18].
    task automatic run_bytes(input int first, input int last);
        for (int j = first; j < last; j++) begin
            vec_t        v;
            logic [27:0] e;
            v = tbl[j % 18];
            send_byte(v.b, 1'b1);
            if (v.strobe) begin
                check("strobe_count", q_pix.size(), 32'd1);
                if (q_pix.size() > 0) begin
                    e = q_pix.pop_front();
                    check("pix_addr", {22'd0, e[27:18]}, ((j % NBYTES) / 18) * 8 + v.pidx);
                    check("pix_data", {14'd0, e[17:0]}, {14'd0, v.pix});
                end
            end else begin
                check("no_strobe", q_pix.size(), 32'd0);
            end
            q_pix.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pix_valid"},  {31'd0, pix_valid},  32'd0);
        check({tag, "_pix_data"},   {14'd0, pix_data},   32'd0);
        check({tag, "_pix_addr"},   {22'd0, pix_addr},   32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_frame_err"},  {31'd0, frame_err},  32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Pixels 0..3: 0x3FFFF, 0, 0, 0  (bytes FF FF C0 00 00 00 00 00 00)
        tbl[0]  = '{8'hFF, 1'b0, 0, 18'h00000};
        tbl[1]  = '{8'hFF, 1'b0, 0, 18'h00000};
        tbl[2]  = '{8'hC0, 1'b1, 0, 18'h3FFFF};
        tbl[3]  = '{8'h00, 1'b0, 0, 18'h00000};
        tbl[4]  = '{8'h00, 1'b1, 1, 18'h00000};
        tbl[5]  = '{8'h00, 1'b0, 0, 18'h00000};
        tbl[6]  = '{8'h00, 1'b1, 2, 18'h00000};
        tbl[7]  = '{8'h00, 1'b0, 0, 18'h00000};
        tbl[8]  = '{8'h00, 1'b1, 3, 18'h00000};
        // Pixels 4..7: 0x12345, 0x2ABCD, 0x00001, 0x3FFFE
        tbl[9]  = '{8'h48, 1'b0, 0, 18'h00000};
        tbl[10] = '{8'hD1, 1'b0, 0, 18'h00000};
        tbl[11] = '{8'h6A, 1'b1, 4, 18'h12345};
        tbl[12] = '{8'hBC, 1'b0, 0, 18'h00000};
        tbl[13] = '{8'hD0, 1'b1, 5, 18'h2ABCD};
        tbl[14] = '{8'h00, 1'b0, 0, 18'h00000};
        tbl[15] = '{8'h07, 1'b1, 6, 18'h00001};
        tbl[16] = '{8'hFF, 1'b0, 0, 18'h00000};
        tbl[17] = '{8'hFE, 1'b1, 7, 18'h3FFFE};

        // Reset state
        rst_n  = 1'b0;
        bit_in = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal frame, including the packing boundary at the start
        run_bytes(0, NBYTES);
        repeat (4) @(negedge clk);
        check("nominal_done_cnt", done_cnt, 32'd1);
        check("nominal_busy",     {31'd0, busy},      32'd0);
        check("nominal_err",      {31'd0, frame_err}, 32'd0);

        // Glitch shorter than half a bit
        bit_in = 1'b0;
        repeat (5) @(negedge clk);
        bit_in = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_strobe", q_pix.size(),     32'd0);
        check("glitch_err",       {31'd0, frame_err}, 32'd0);
        check("glitch_busy",      {31'd0, busy},      32'd0);

        // Bad stop bit on byte 2: dropped, error latched, frame kept
        run_bytes(0, 2);
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("badstop_err",       {31'd0, frame_err}, 32'd1);
        check("badstop_no_strobe", q_pix.size(),      32'd0);
        check("badstop_busy",      {31'd0, busy},      32'd1);
        run_bytes(2, NBYTES);
        repeat (4) @(negedge clk);
        check("badstop_done_cnt", done_cnt,        32'd2);
        check("badstop_busy_end", {31'd0, busy},   32'd0);

        // Timeout: partial frame then long idle
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_clears_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_bytes(0, 10);
        repeat (TO - 40) @(negedge clk);
        check("pre_timeout_busy", {31'd0, busy},      32'd1);
        check("pre_timeout_err",  {31'd0, frame_err}, 32'd0);
        repeat (80) @(negedge clk);
        check("timeout_err",       {31'd0, frame_err}, 32'd1);
        check("timeout_busy",      {31'd0, busy},      32'd0);
        check("timeout_no_strobe", q_pix.size(),      32'd0);
        done_cnt = 0;
        run_bytes(0, NBYTES);
        repeat (4) @(negedge clk);
        check("timeout_next_done", done_cnt, 32'd1);

        // Reset mid-DATA, then two back-to-back frames
        run_bytes(0, 3);
        bit_in = 1'b0;
        repeat (60) @(negedge clk);
        rst_n  = 1'b0;
        bit_in = 1'b1;
        @(negedge clk);
        check_zero_outputs("midreset");
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        done_cnt = 0;
        q_pix.delete();
        run_bytes(0, 2 * NBYTES);
        repeat (4) @(negedge clk);
        check("b2b_done_cnt", done_cnt,          32'd2);
        check("b2b_busy",     {31'd0, busy},      32'd0);
        check("b2b_err",      {31'd0, frame_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_pixel.md
# uart_rx_pixel

Serial front end of the LeNet-5 datapath. It receives the 8N1 UART stream on `bit_in`, rebuilds the 14112-bit image frame, and emits it as 784 pixels of 18 bits (28×28), one pixel per strobe with its address, for the pixel buffer that feeds `lenet5`. It also signals frame completion and latches link errors.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clocks per UART bit (50 MHz / 115200). Must be at least 8.
- `PIX_W`, default 18: pixel width.
- `N_PIX`, default 784: pixels per frame.
- `TIMEOUT`, default 16×`CLKS_PER_BIT`: idle clocks allowed between bytes inside a frame.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `bit_in`  in  1: UART RX line, idle high, asynchronous to `clk`.
- `pix_valid`  out  1: one-cycle strobe; `pix_data` and `pix_addr` are valid while it is high.
- `pix_data`  out  `PIX_W`: pixel value.
- `pix_addr`  out  10: pixel index, 0..`N_PIX`-1.
- `frame_done`  out  1: one-cycle pulse, coincident with the `pix_valid` of pixel `N_PIX`-1.
- `frame_err`  out  1: sticky error flag; cleared only by reset.
- `busy`  out  1: high while a frame is partially received (byte count nonzero).

## Operation
Input conditioning:
- `bit_in` passes through a 2-flop synchronizer. Both flops reset to 1.

RX state machine:
- **IDLE**: a low on the synced line moves to START and clears the bit timer.
- **START**: wait `CLKS_PER_BIT`/2 clocks, then resample. Low goes to DATA. High is a glitch and returns to IDLE with no error.
- **DATA**: wait `CLKS_PER_BIT` clocks per bit and sample 8 bits. The first bit sampled is the byte LSB. After bit 7, go to STOP.
- **STOP**: wait `CLKS_PER_BIT` clocks and sample.
  - 1: the byte is accepted.
  - 0: the byte is dropped and `frame_err` is set.
  - Either way, return to IDLE in the next cycle, so a back-to-back start bit is caught.

Packing:
- Frame vector F[14111:0]. Received byte k (0-based) occupies F[14111-8k -: 8], so the first byte is the MSBs.
- Pixel n = F[14111-18n -: 18].
- Implementation: a 26-bit accumulator plus a fill count. Each accepted byte is appended at the LSB end and adds 8 to the count.
- When the fill count reaches 18 or more, the top 18 valid bits are emitted and the count drops by 18. At most one pixel is produced per byte.
- 1764 bytes yield exactly 784 pixels with an empty accumulator.
- `pix_addr` increments per pixel.
- After pixel 783: `frame_done` pulses, and the byte count, pixel count and accumulator clear. The block is ready for the next frame with no reset.

Timeout:
- While `busy` and the RX is in IDLE, an idle counter runs.
- At `TIMEOUT` clocks, the partial frame is discarded: counts and accumulator clear and `frame_err` is set.
- The counter clears on every start-bit detection.

## Timing
- Reset values:
  - outputs: `pix_valid`=0, `pix_data`=0, `pix_addr`=0, `frame_done`=0, `frame_err`=0, `busy`=0.
  - internal: FSM in IDLE, all counters 0.
- Reset asserted mid-byte or mid-frame aborts immediately. The first start bit after release begins byte 0 / pixel 0.
- The start edge is seen 2 clocks after the `bit_in` fall (synchronizer).
- The stop sample occurs (0.5 + 9)×`CLKS_PER_BIT` clocks after edge detection.
- `pix_valid` rises 1 clock after the stop sample of the completing byte and is high for exactly 1 clock. `pix_data` and `pix_addr` hold until the next strobe.
- Data bits and stop bit are each a single centre sample; no majority vote.
- Simultaneous timeout expiry and start-bit detection: start wins, and the frame is kept.
- A framing error does not clear the partial frame. Only a timeout or reset does.

## Test plan
- **Nominal frame**: `CLKS_PER_BIT`=16; send 1764 bytes encoding pixel n = n (18-bit) -> 784 strobes with `pix_addr`=n and `pix_data`=n; `frame_done` coincides with addr 783; `frame_err`=0; `busy`=0 afterward.
- **Packing boundary**: first 9 bytes are 0xFF,0xFF,0xC0,0x00,... -> pixel0=0x3FFFF, pixel1=0x00000; pixels 0..3 strobe after bytes 3, 5, 7, 9.
- **Glitch**: `bit_in` low for 5 clocks (< 8) -> no state advance, no strobe, no error.
- **Bad stop bit**: byte 2 sent with stop=0 -> `frame_err`=1; the byte is dropped; the next good byte is packed as byte 2.
- **Timeout**: stop after 100 bytes and idle for `TIMEOUT`+1 clocks -> `frame_err`=1, `busy`=0; a following full frame starts at `pix_addr`=0 with correct data.
- **Reset and back-to-back**: assert `rst_n` mid-DATA, then send two frames with zero inter-byte gap -> all outputs 0 during reset; two `frame_done` pulses, 784 strobes each.
